mem_controller_rr: RTL

// Multi-channel memory controller between NUM_CONSUMERS requesters (fetchers/LSUs) and
// NUM_CHANNELS global-memory channels. Round-robin fair arbitration replaces fixed-priority

---
 rtl/mem_controller_rr_pkg.sv | 25 ++
 rtl/mem_arbiter_rr.sv | 57 +++++
 rtl/mem_controller_rr.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_controller_rr_pkg
//  Brief    : Shared channel-state encoding and index-width helper for the
//             round-robin memory controller.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_controller_rr_pkg;

   // Per-channel controller state
   typedef enum logic [2:0] {
      CONTROLLER_IDLE = 3'd0,
      READ_WAITING    = 3'd1,
      WRITE_WAITING   = 3'd2,
      READ_RELAYING   = 3'd3,
      WRITE_RELAYING  = 3'd4
   } controller_state_t;

   // Index width that never collapses to zero for a single requester
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_rr
//  Brief    : Combinational multi-grant round-robin picker. Idle channels in
//             ascending order each take the next unclaimed eligible consumer,
//             scanning upward from the round-robin pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr
   import mem_controller_rr_pkg::*;
#(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int IDX_BITS      = clog2_min1(NUM_CONSUMERS)
) (
   input  logic [NUM_CONSUMERS-1:0]         i_eligible,
   input  logic [NUM_CHANNELS-1:0]          i_idle,
   input  logic [IDX_BITS-1:0]              i_rr_ptr,
   output logic [NUM_CHANNELS-1:0]          o_grant_valid,
   output logic [NUM_CHANNELS*IDX_BITS-1:0] o_grant_idx,
   output logic [IDX_BITS-1:0]              o_next_ptr
);

   logic [NUM_CONSUMERS-1:0] w_avail;
   logic                     w_found;
   logic                     w_any;
   logic [IDX_BITS-1:0]      w_cand;
   logic [IDX_BITS-1:0]      w_last;

   // Sequential scan: a consumer taken by a lower channel is removed from the pool
   always_comb begin
      w_avail       = i_eligible;
      w_found       = 1'b0;
      w_any         = 1'b0;
      w_cand        = '0;
      w_last        = '0;
      o_grant_valid = '0;
      o_grant_idx   = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         w_found = 1'b0;
         for (int k = 0; k < NUM_CONSUMERS; k++) begin
            w_cand = IDX_BITS'((int'(i_rr_ptr) + k) % NUM_CONSUMERS);
            if (i_idle[ch] && !w_found && w_avail[w_cand]) begin
               w_found                                 = 1'b1;
               w_any                                   = 1'b1;
               w_last                                  = w_cand;
               w_avail[w_cand]                         = 1'b0;
               o_grant_valid[ch]                       = 1'b1;
               o_grant_idx[ch*IDX_BITS +: IDX_BITS]    = w_cand;
            end
         end
      end
      o_next_ptr = w_any ? IDX_BITS'((int'(w_last) + 1) % NUM_CONSUMERS) : i_rr_ptr;
   end

endmodule
`default_nettype wire

// File: rtl/mem_controller_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_controller_rr
//  Brief    : Multi-channel memory controller with round-robin arbitration
//             between consumers (fetchers/LSUs) and global-memory channels.
//             Write path is removed when WRITE_ENABLE = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_controller_rr
   import mem_controller_rr_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
   output logic [NUM_CHANNELS-1:0]            channel_busy
);

   localparam int c_IDX_BITS = clog2_min1(NUM_CONSUMERS);

   // Unpacked views of the flattened buses
   logic [ADDR_BITS-1:0]  w_rd_addr     [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]  w_wr_addr     [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]  w_wr_data     [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]  w_mem_rd_data [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] w_write_req;

   // Channel state
   controller_state_t     r_state       [NUM_CHANNELS];
   controller_state_t     w_state_nxt   [NUM_CHANNELS];
   logic [c_IDX_BITS-1:0] r_owner       [NUM_CHANNELS];
   logic [c_IDX_BITS-1:0] w_owner_nxt   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] r_mem_read_valid,  w_mem_read_valid_nxt;
   logic [NUM_CHANNELS-1:0] r_mem_write_valid, w_mem_write_valid_nxt;
   logic [ADDR_BITS-1:0]  r_mem_read_address  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]  w_mem_read_address_nxt  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]  r_mem_write_address [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]  w_mem_write_address_nxt [NUM_CHANNELS];
   logic [DATA_BITS-1:0]  r_mem_write_data    [NUM_CHANNELS];
   logic [DATA_BITS-1:0]  w_mem_write_data_nxt    [NUM_CHANNELS];

   // Consumer-facing state
   logic [NUM_CONSUMERS-1:0] r_cons_read_ready,  w_cons_read_ready_nxt;
   logic [NUM_CONSUMERS-1:0] r_cons_write_ready, w_cons_write_ready_nxt;
   logic [DATA_BITS-1:0]     r_cons_read_data     [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     w_cons_read_data_nxt [NUM_CONSUMERS];

   // Arbitration
   logic [c_IDX_BITS-1:0]              r_rr_ptr;
   logic [c_IDX_BITS-1:0]              w_next_ptr;
   logic [NUM_CHANNELS-1:0]            w_idle;
   logic [NUM_CONSUMERS-1:0]           w_claimed;
   logic [NUM_CONSUMERS-1:0]           w_eligible;
   logic [NUM_CHANNELS-1:0]            w_grant_valid;
   logic [NUM_CHANNELS*c_IDX_BITS-1:0] w_grant_idx;
   logic [c_IDX_BITS-1:0]              w_gidx;

   generate
      for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_cons
         assign w_rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
         assign w_wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
         assign w_wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
         assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = r_cons_read_data[i];
      end

      for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
         assign w_mem_rd_data[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
         assign mem_read_address[c*ADDR_BITS +: ADDR_BITS] = r_mem_read_address[c];
      end

      if (WRITE_ENABLE != 0) begin : g_write
         assign w_write_req          = consumer_write_valid;
         assign mem_write_valid      = r_mem_write_valid;
         assign consumer_write_ready = r_cons_write_ready;
         for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_wr_pack
            assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = r_mem_write_address[c];
            assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = r_mem_write_data[c];
         end
      end else begin : g_no_write
         assign w_write_req          = '0;
         assign mem_write_valid      = '0;
         assign consumer_write_ready = '0;
         assign mem_write_address    = '0;
         assign mem_write_data       = '0;
      end
   endgenerate

   assign consumer_read_ready = r_cons_read_ready;
   assign mem_read_valid      = r_mem_read_valid;
   assign channel_busy        = ~w_idle;

   // A consumer stays claimed while any channel holds it outside IDLE
   always_comb begin
      w_claimed = '0;
      w_idle    = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (r_state[ch] == CONTROLLER_IDLE) w_idle[ch] = 1'b1;
         else                                w_claimed[r_owner[ch]] = 1'b1;
      end
   end

   assign w_eligible = (consumer_read_valid | w_write_req) & ~w_claimed;

   mem_arbiter_rr #(
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .NUM_CHANNELS  (NUM_CHANNELS),
      .IDX_BITS      (c_IDX_BITS)
   ) u_arbiter (
      .i_eligible    (w_eligible),
      .i_idle        (w_idle),
      .i_rr_ptr      (r_rr_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx),
      .o_next_ptr    (w_next_ptr)
   );

   // Per-channel next-state and registered-output computation
   always_comb begin
      w_state_nxt             = r_state;
      w_owner_nxt             = r_owner;
      w_mem_read_valid_nxt    = r_mem_read_valid;
      w_mem_write_valid_nxt   = r_mem_write_valid;
      w_mem_read_address_nxt  = r_mem_read_address;
      w_mem_write_address_nxt = r_mem_write_address;
      w_mem_write_data_nxt    = r_mem_write_data;
      w_cons_read_ready_nxt   = r_cons_read_ready;
      w_cons_write_ready_nxt  = r_cons_write_ready;
      w_cons_read_data_nxt    = r_cons_read_data;
      w_gidx                  = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         w_gidx = w_grant_idx[ch*c_IDX_BITS +: c_IDX_BITS];
         case (r_state[ch])
            CONTROLLER_IDLE: begin
               if (w_grant_valid[ch]) begin
                  w_owner_nxt[ch] = w_gidx;
                  // Read takes precedence; a pending write waits for a later grant
                  if (consumer_read_valid[w_gidx]) begin
                     w_state_nxt[ch]            = READ_WAITING;
                     w_mem_read_valid_nxt[ch]   = 1'b1;
                     w_mem_read_address_nxt[ch] = w_rd_addr[w_gidx];
                  end else begin
                     w_state_nxt[ch]             = WRITE_WAITING;
                     w_mem_write_valid_nxt[ch]   = 1'b1;
                     w_mem_write_address_nxt[ch] = w_wr_addr[w_gidx];
                     w_mem_write_data_nxt[ch]    = w_wr_data[w_gidx];
                  end
               end
            end
            READ_WAITING: begin
               if (mem_read_ready[ch]) begin
                  w_state_nxt[ch]                   = READ_RELAYING;
                  w_mem_read_valid_nxt[ch]          = 1'b0;
                  w_cons_read_ready_nxt[r_owner[ch]] = 1'b1;
                  w_cons_read_data_nxt[r_owner[ch]]  = w_mem_rd_data[ch];
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready[ch]) begin
                  w_state_nxt[ch]                    = WRITE_RELAYING;
                  w_mem_write_valid_nxt[ch]          = 1'b0;
                  w_cons_write_ready_nxt[r_owner[ch]] = 1'b1;
               end
            end
            READ_RELAYING: begin
               if (!consumer_read_valid[r_owner[ch]]) begin
                  w_state_nxt[ch]                   = CONTROLLER_IDLE;
                  w_cons_read_ready_nxt[r_owner[ch]] = 1'b0;
               end
            end
            WRITE_RELAYING: begin
               if (!w_write_req[r_owner[ch]]) begin
                  w_state_nxt[ch]                    = CONTROLLER_IDLE;
                  w_cons_write_ready_nxt[r_owner[ch]] = 1'b0;
               end
            end
            default: w_state_nxt[ch] = CONTROLLER_IDLE;
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            r_state[ch]             <= CONTROLLER_IDLE;
            r_owner[ch]             <= '0;
            r_mem_read_address[ch]  <= '0;
            r_mem_write_address[ch] <= '0;
            r_mem_write_data[ch]    <= '0;
         end
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            r_cons_read_data[i] <= '0;
         end
         r_mem_read_valid   <= '0;
         r_mem_write_valid  <= '0;
         r_cons_read_ready  <= '0;
         r_cons_write_ready <= '0;
         r_rr_ptr           <= '0;
      end else begin
         r_state             <= w_state_nxt;
         r_owner             <= w_owner_nxt;
         r_mem_read_address  <= w_mem_read_address_nxt;
         r_mem_write_address <= w_mem_write_address_nxt;
         r_mem_write_data    <= w_mem_write_data_nxt;
         r_cons_read_data    <= w_cons_read_data_nxt;
         r_mem_read_valid    <= w_mem_read_valid_nxt;
         r_mem_write_valid   <= w_mem_write_valid_nxt;
         r_cons_read_ready   <= w_cons_read_ready_nxt;
         r_cons_write_ready  <= w_cons_write_ready_nxt;
         r_rr_ptr            <= w_next_ptr;
      end
   end

endmodule
`default_nettype wire
